// File: rtl/timer_pkg.sv
// timer_pkg: register offsets, CTRL field positions, AXI response codes and
// channel FSM encodings shared by axi4lite_timer and its bench.
`ifndef ALEN
`define ALEN 12
`endif

package timer_pkg;

    localparam logic [4:0] TIMER_MTIME_OFF    = 5'h00;
    localparam logic [4:0] TIMER_MTIMECMP_OFF = 5'h08;
    localparam logic [4:0] TIMER_CTRL_OFF     = 5'h10;

    localparam int CTRL_EN_BIT  = 0;
    localparam int CTRL_PSC_LSB = 8;
    localparam int CTRL_PSC_MSB = 15;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic {W_IDLE, W_RESP} wstate_t;
    typedef enum logic {R_IDLE, R_RESP} rstate_t;

    // Byte-lane merge: strobe bit i replaces bits [8i+7:8i].
    function automatic logic [63:0] strb_merge(input logic [63:0] old_v,
                                               input logic [63:0] new_v,
                                               input logic [7:0]  strb);
        logic [63:0] res;
        res = old_v;
        for (int i = 0; i < 8; i++) begin
            if (strb[i]) res[8*i +: 8] = new_v[8*i +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/timer_prescaler.sv
// timer_prescaler: 8-bit divider producing an MTIME tick every PRESCALE+1
// enabled cycles; used only when TIMER_PRESCALER_EN is defined.
module timer_prescaler (
    input  logic       aclk,
    input  logic       aresetn,
    input  logic       en,
    input  logic [7:0] prescale,
    input  logic       prescale_wr,
    output logic       tick
);

    logic [7:0] r_div;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_div <= '0;
        end else if (prescale_wr) begin
            r_div <= '0;
        end else if (en) begin
            r_div <= (r_div == prescale) ? 8'd0 : r_div + 8'd1;
        end
    end

    assign tick = en && (r_div == prescale);

endmodule

// File: rtl/axi4lite_timer.sv
// axi4lite_timer: mtime/mtimecmp machine timer on a 64-bit AXI4-Lite slave with
// a registered level irq. Optional divider enabled by macro TIMER_PRESCALER_EN.
module axi4lite_timer
    import timer_pkg::*;
#(
    parameter int                    ADDR_WIDTH = `ALEN,
    parameter logic [ADDR_WIDTH-1:0] ADDR_MASK  = {3'b000, {(`ALEN-3){1'b1}}},
    parameter logic [63:0]           CMP_RESET  = 64'hFFFF_FFFF_FFFF_FFFF
) (
    input  logic                  aclk,
    input  logic                  aresetn,
    input  logic [ADDR_WIDTH-1:0] awaddr,
    input  logic [2:0]            awprot,
    input  logic                  awvalid,
    output logic                  awready,
    input  logic [63:0]           wdata,
    input  logic [7:0]            wstrb,
    input  logic                  wvalid,
    output logic                  wready,
    output logic [1:0]            bresp,
    output logic                  bvalid,
    input  logic                  bready,
    input  logic [ADDR_WIDTH-1:0] araddr,
    input  logic [2:0]            arprot,
    input  logic                  arvalid,
    output logic                  arready,
    output logic [63:0]           rdata,
    output logic [1:0]            rresp,
    output logic                  rvalid,
    input  logic                  rready,
    output logic                  irq
);

    wstate_t               r_wstate, w_wstate_nxt;
    rstate_t               r_rstate, w_rstate_nxt;
    logic                  r_live;
    logic                  r_aw_got, r_w_got;
    logic [ADDR_WIDTH-1:0] r_awaddr;
    logic [63:0]           r_wdata;
    logic [7:0]            r_wstrb;
    logic [1:0]            r_bresp, r_rresp;
    logic [63:0]           r_rdata;
    logic [63:0]           r_mtime, r_mtimecmp;
    logic                  r_en, r_irq;
    logic [7:0]            w_prescale;
    logic                  w_tick;

    logic                  w_aw_hs, w_w_hs, w_ar_hs, w_commit;
    logic [ADDR_WIDTH-1:0] w_waddr, w_wmasked, w_rmasked;
    logic [63:0]           w_wd;
    logic [7:0]            w_ws;
    logic [4:0]            w_woff, w_roff;
    logic                  w_wr_mtime, w_wr_cmp, w_wr_ctrl, w_wr_err;
    logic [63:0]           w_ctrl, w_rd_data;
    logic [1:0]            w_rd_resp;
    logic                  w_unused;

    assign w_aw_hs  = awvalid && awready;
    assign w_w_hs   = wvalid && wready;
    assign w_ar_hs  = arvalid && arready;
    assign w_commit = (r_wstate == W_IDLE) && (r_aw_got || w_aw_hs) && (r_w_got || w_w_hs);

    // A beat latched on an earlier cycle takes precedence over the live bus.
    assign w_waddr   = r_aw_got ? r_awaddr : awaddr;
    assign w_wd      = r_w_got ? r_wdata : wdata;
    assign w_ws      = r_w_got ? r_wstrb : wstrb;
    assign w_wmasked = w_waddr & ADDR_MASK;
    assign w_rmasked = araddr & ADDR_MASK;
    assign w_woff    = w_wmasked[4:0];
    assign w_roff    = w_rmasked[4:0];

    assign w_wr_mtime = w_commit && (w_woff == TIMER_MTIME_OFF);
    assign w_wr_cmp   = w_commit && (w_woff == TIMER_MTIMECMP_OFF);
    assign w_wr_ctrl  = w_commit && (w_woff == TIMER_CTRL_OFF);
    assign w_wr_err   = !((w_woff == TIMER_MTIME_OFF) || (w_woff == TIMER_MTIMECMP_OFF)
                          || (w_woff == TIMER_CTRL_OFF));

    assign w_unused = &{1'b0, awprot, arprot, w_wmasked[ADDR_WIDTH-1:5], w_rmasked[ADDR_WIDTH-1:5]};

`ifdef TIMER_PRESCALER_EN
    logic [7:0] r_prescale;
    logic       w_psc_wr;

    assign w_psc_wr   = w_wr_ctrl && w_ws[CTRL_PSC_LSB/8];
    assign w_prescale = r_prescale;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_prescale <= '0;
        end else if (w_psc_wr) begin
            r_prescale <= w_wd[CTRL_PSC_MSB:CTRL_PSC_LSB];
        end
    end

    timer_prescaler u_prescaler (
        .aclk        (aclk),
        .aresetn     (aresetn),
        .en          (r_en),
        .prescale    (r_prescale),
        .prescale_wr (w_psc_wr),
        .tick        (w_tick)
    );
`else
    assign w_prescale = 8'd0;
    assign w_tick     = r_en;
`endif

    assign w_ctrl = {48'd0, w_prescale, 7'd0, r_en};

    // FSM state registers; r_live holds the readies low for the first cycle out of reset.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_wstate <= W_IDLE;
            r_rstate <= R_IDLE;
            r_live   <= 1'b0;
        end else begin
            r_wstate <= w_wstate_nxt;
            r_rstate <= w_rstate_nxt;
            r_live   <= 1'b1;
        end
    end

    always_comb begin
        w_wstate_nxt = r_wstate;
        case (r_wstate)
            W_IDLE:  if (w_commit) w_wstate_nxt = W_RESP;
            W_RESP:  if (bready) w_wstate_nxt = W_IDLE;
            default: w_wstate_nxt = W_IDLE;
        endcase
    end

    always_comb begin
        w_rstate_nxt = r_rstate;
        case (r_rstate)
            R_IDLE:  if (w_ar_hs) w_rstate_nxt = R_RESP;
            R_RESP:  if (rready) w_rstate_nxt = R_IDLE;
            default: w_rstate_nxt = R_IDLE;
        endcase
    end

    always_comb begin
        awready = r_live && (r_wstate == W_IDLE) && !r_aw_got;
        wready  = r_live && (r_wstate == W_IDLE) && !r_w_got;
        bvalid  = (r_wstate == W_RESP);
        bresp   = r_bresp;
        arready = r_live && (r_rstate == R_IDLE);
        rvalid  = (r_rstate == R_RESP);
        rdata   = r_rdata;
        rresp   = r_rresp;
        irq     = r_irq;
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_aw_got <= 1'b0;
            r_w_got  <= 1'b0;
            r_awaddr <= '0;
            r_wdata  <= '0;
            r_wstrb  <= '0;
            r_bresp  <= RESP_OKAY;
        end else if (w_commit) begin
            r_aw_got <= 1'b0;
            r_w_got  <= 1'b0;
            r_bresp  <= w_wr_err ? RESP_SLVERR : RESP_OKAY;
        end else begin
            if (w_aw_hs) begin
                r_aw_got <= 1'b1;
                r_awaddr <= awaddr;
            end
            if (w_w_hs) begin
                r_w_got <= 1'b1;
                r_wdata <= wdata;
                r_wstrb <= wstrb;
            end
        end
    end

    // Software writes to MTIME override the tick in the same cycle.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_mtime    <= '0;
            r_mtimecmp <= CMP_RESET;
            r_en       <= 1'b1;
            r_irq      <= 1'b0;
        end else begin
            if (w_wr_mtime) r_mtime <= strb_merge(r_mtime, w_wd, w_ws);
            else if (w_tick) r_mtime <= r_mtime + 64'd1;
            if (w_wr_cmp) r_mtimecmp <= strb_merge(r_mtimecmp, w_wd, w_ws);
            if (w_wr_ctrl && w_ws[0]) r_en <= w_wd[CTRL_EN_BIT];
            r_irq <= (r_mtime >= r_mtimecmp);
        end
    end

    always_comb begin
        w_rd_data = '0;
        w_rd_resp = RESP_OKAY;
        case (w_roff)
            TIMER_MTIME_OFF:    w_rd_data = r_mtime;
            TIMER_MTIMECMP_OFF: w_rd_data = r_mtimecmp;
            TIMER_CTRL_OFF:     w_rd_data = w_ctrl;
            default:            w_rd_resp = RESP_SLVERR;
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_rdata <= '0;
            r_rresp <= RESP_OKAY;
        end else if (w_ar_hs) begin
            r_rdata <= w_rd_data;
            r_rresp <= w_rd_resp;
        end
    end

endmodule

// File: tb/tb_axi4lite_timer.sv
// tb_axi4lite_timer: randomized bus traffic against an arithmetic model of
// mtime/mtimecmp/irq (mtime as base value plus elapsed enabled cycles).
`timescale 1ns/1ps
module tb_axi4lite_timer;

    localparam int AW = `ALEN;
    localparam logic [AW-1:0] MASK = {3'b000, {(AW-3){1'b1}}};

    logic          aclk = 1'b0;
    logic          aresetn = 1'b0;
    logic [AW-1:0] awaddr = '0, araddr = '0;
    logic [2:0]    awprot = '0, arprot = '0;
    logic          awvalid = 1'b0, wvalid = 1'b0, bready = 1'b0, arvalid = 1'b0, rready = 1'b0;
    logic [63:0]   wdata = '0;
    logic [7:0]    wstrb = '0;
    logic          awready, wready, bvalid, arready, rvalid, irq;
    logic [1:0]    bresp, rresp;
    logic [63:0]   rdata;

    always #5 aclk = ~aclk;

    axi4lite_timer dut (
        .aclk(aclk), .aresetn(aresetn),
        .awaddr(awaddr), .awprot(awprot), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
        .bresp(bresp), .bvalid(bvalid), .bready(bready),
        .araddr(araddr), .arprot(arprot), .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
        .irq(irq)
    );

    int     n_chk = 0;
    int     n_err = 0;
    longint cyc = 0;

    // Model: mtime after edge n = m_val + (n - m_cyc) while enabled, else m_val.
    logic [63:0] m_val = '0;
    logic [63:0] m_cmp = 64'hFFFF_FFFF_FFFF_FFFF;
    longint      m_cyc = 0;
    logic        m_en = 1'b1;
    logic [7:0]  m_psc = 8'd0;

    logic [AW-1:0] addr_tab [8];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge aclk);
        cyc++;
        #1;
    endtask

    function automatic logic [63:0] mt(input longint n);
        return m_en ? m_val + 64'(n - m_cyc) : m_val;
    endfunction

    function automatic logic [63:0] merge(input logic [63:0] o, input logic [63:0] d, input logic [7:0] s);
        logic [63:0] r;
        r = o;
        for (int i = 0; i < 8; i++) if (s[i]) r[8*i +: 8] = d[8*i +: 8];
        return r;
    endfunction

    function automatic logic [4:0] moff(input logic [AW-1:0] a);
        logic [AW-1:0] m;
        m = a & MASK;
        return m[4:0];
    endfunction

    function automatic logic mapped(input logic [AW-1:0] a);
        logic [4:0] o;
        o = moff(a);
        return (o == 5'h00) || (o == 5'h08) || (o == 5'h10);
    endfunction

    task automatic model_write(input logic [AW-1:0] a, input logic [63:0] d, input logic [7:0] s, input longint c);
        case (moff(a))
            5'h00: begin m_val = merge(mt(c - 1), d, s); m_cyc = c; end
            5'h08: m_cmp = merge(m_cmp, d, s);
            5'h10: begin
                m_val = mt(c);
                m_cyc = c;
                if (s[0]) m_en = d[0];
`ifdef TIMER_PRESCALER_EN
                if (s[1]) m_psc = d[15:8];
`endif
            end
            default: ;
        endcase
    endtask

    function automatic logic [63:0] model_read(input logic [AW-1:0] a, input longint n);
        case (moff(a))
            5'h00:   return mt(n);
            5'h08:   return m_cmp;
            5'h10:   return {48'd0, m_psc, 7'd0, m_en};
            default: return 64'd0;
        endcase
    endfunction

    task automatic chk_irq();
        chk("irq", {63'd0, irq}, {63'd0, (mt(cyc - 1) >= m_cmp)});
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            step();
            chk_irq();
        end
    endtask

    task automatic wr(input logic [AW-1:0] a, input logic [63:0] d, input logic [7:0] s,
                      input int aw_lead, input int b_hold);
        int         t;
        longint     c;
        logic [1:0] er;
        er = mapped(a) ? 2'b00 : 2'b10;
        t = 0;
        while (!(awready && wready) && t < 50) begin
            step();
            t++;
        end
        if (t >= 50) begin
            chk("wr_ready_timeout", 64'd0, 64'd1);
            return;
        end
        awaddr = a; wdata = d; wstrb = s; awvalid = 1'b1;
        if (aw_lead > 0) begin
            step();
            awvalid = 1'b0;
            chk("awready_after_aw", {63'd0, awready}, 64'd0);
            chk("wready_waiting", {63'd0, wready}, 64'd1);
            repeat (aw_lead - 1) step();
            chk("bvalid_before_w", {63'd0, bvalid}, 64'd0);
        end
        wvalid = 1'b1;
        step();
        c = cyc;
        awvalid = 1'b0;
        wvalid = 1'b0;
        model_write(a, d, s, c);
        repeat (b_hold) begin
            chk("bvalid_hold", {63'd0, bvalid}, 64'd1);
            chk("awready_in_resp", {63'd0, awready}, 64'd0);
            step();
        end
        chk("bvalid", {63'd0, bvalid}, 64'd1);
        chk("bresp", {62'd0, bresp}, {62'd0, er});
        bready = 1'b1;
        step();
        bready = 1'b0;
        chk("bvalid_clear", {63'd0, bvalid}, 64'd0);
    endtask

    task automatic rd(input logic [AW-1:0] a, output logic [63:0] d, output logic [1:0] r, output longint ae);
        int t;
        t = 0;
        while (!arready && t < 50) begin
            step();
            t++;
        end
        if (t >= 50) begin
            chk("rd_ready_timeout", 64'd0, 64'd1);
            d = '0; r = '0; ae = cyc;
            return;
        end
        araddr = a;
        arvalid = 1'b1;
        step();
        ae = cyc;
        arvalid = 1'b0;
        chk("rvalid", {63'd0, rvalid}, 64'd1);
        chk("arready_in_resp", {63'd0, arready}, 64'd0);
        d = rdata;
        r = rresp;
        t = int'($urandom_range(0, 2));
        repeat (t) begin
            step();
            chk("rdata_hold", rdata, d);
        end
        rready = 1'b1;
        step();
        rready = 1'b0;
        chk("rvalid_clear", {63'd0, rvalid}, 64'd0);
    endtask

    task automatic rd_chk(input string tag, input logic [AW-1:0] a);
        logic [63:0] d;
        logic [1:0]  r;
        longint      e;
        rd(a, d, r, e);
        chk(tag, d, model_read(a, e - 1));
        chk({tag, "_resp"}, {62'd0, r}, mapped(a) ? 64'd0 : 64'd2);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int            op;
        logic [7:0]    s;
        logic [63:0]   d0, d1, d2, d3;
        logic [1:0]    r0;
        longint        e0;
        logic [AW-1:0] a;

        addr_tab[0] = 'h000; addr_tab[1] = 'h008; addr_tab[2] = 'h010; addr_tab[3] = 'h018;
        addr_tab[4] = 'h004; addr_tab[5] = 'h00C; addr_tab[6] = 'h808; addr_tab[7] = 'h113;

        repeat (3) step();
        chk("rst_awready", {63'd0, awready}, 64'd0);
        chk("rst_wready", {63'd0, wready}, 64'd0);
        chk("rst_arready", {63'd0, arready}, 64'd0);
        chk("rst_bvalid", {63'd0, bvalid}, 64'd0);
        chk("rst_rvalid", {63'd0, rvalid}, 64'd0);
        chk("rst_irq", {63'd0, irq}, 64'd0);
        chk("rst_rdata", rdata, 64'd0);
        chk("rst_resp", {60'd0, bresp, rresp}, 64'd0);

        aresetn = 1'b1;
        m_cyc = cyc;
        step();
        chk("post_rst_ready", {61'd0, awready, wready, arready}, 64'd7);
        repeat (9) step();
        rd_chk("mtime_idle", 'h000);
        chk_irq();
        rd_chk("cmp_reset", 'h008);
        rd_chk("ctrl_reset", 'h010);

        wr('h008, 64'd100, 8'hFF, 0, 0);
        wr('h000, 64'd95, 8'hFF, 0, 0);
        chk_irq();
        idle(10);
        wr('h008, 64'd1000, 8'hFF, 0, 0);
        chk_irq();

        wr('h008, 64'h0000_0100_0000_0000, 8'hFF, 3, 4);
        rd_chk("cmp_aw_lead", 'h008);
        wr('h008, 64'hAAAA_BBBB_CCCC_DDDD, 8'h0F, 0, 1);
        rd_chk("cmp_partial", 'h008);

        wr('h008, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, 0, 0);
        wr('h000, 64'hFFFF_FFFF_FFFF_FFFE, 8'hFF, 0, 0);
        idle(4);
        rd_chk("mtime_wrap", 'h000);

        wr('h00C, 64'h1234_5678_9ABC_DEF0, 8'hFF, 0, 0);
        wr('h018, 64'h1111_2222_3333_4444, 8'hFF, 1, 0);
        rd_chk("unmapped_18", 'h018);
        rd_chk("unmapped_0C", 'h00C);
        rd_chk("cmp_after_unmapped", 'h008);
        rd_chk("ctrl_after_unmapped", 'h010);
        rd_chk("alias_cmp", 'h808);

        wr('h010, 64'h0301, 8'h01, 0, 0);
        rd_chk("ctrl_en_only", 'h010);
        wr('h010, 64'h0, 8'h01, 0, 0);
        idle(3);
        rd_chk("mtime_frozen", 'h000);
        wr('h010, 64'h1, 8'h01, 0, 0);
        idle(2);
        rd_chk("mtime_resumed", 'h000);

        for (int i = 0; i < 60; i++) begin
            op = int'($urandom_range(0, 5));
            s = ($urandom_range(0, 1) == 1) ? 8'hFF : 8'($urandom);
            case (op)
                0: wr('h000, m_cmp - 64'($urandom_range(0, 12)), s,
                      int'($urandom_range(0, 2)), int'($urandom_range(0, 2)));
                1: wr('h008, mt(cyc) + 64'($urandom_range(0, 20)) - 64'd5, s,
                      int'($urandom_range(0, 2)), int'($urandom_range(0, 2)));
                2: wr('h010, {32'($urandom), 32'($urandom)} & 64'hFFFF_FFFF_FFFF_00FF, s, 0,
                      int'($urandom_range(0, 1)));
                3: begin
                    a = addr_tab[$urandom_range(0, 7)];
                    rd_chk("rnd_read", a);
                end
                4: begin
                    a = addr_tab[3 + $urandom_range(0, 2)];
                    if (a == 'h005) a = 'h018;
                    if (mapped(a)) a = 'h018;
                    wr(a, {32'($urandom), 32'($urandom)}, s, 0, 0);
                end
                default: idle(int'($urandom_range(1, 6)));
            endcase
            chk_irq();
        end
        rd_chk("final_mtime", 'h000);
        rd_chk("final_cmp", 'h008);

`ifdef TIMER_PRESCALER_EN
        wr('h010, 64'h0301, 8'h03, 0, 0);
        rd('h000, d0, r0, e0);
        while (cyc < e0 + 99) step();
        rd('h000, d1, r0, e0);
        chk("psc_rate_25pm1", {63'd0, ((d1 - d0) >= 64'd24) && ((d1 - d0) <= 64'd26)}, 64'd1);
        wr('h010, 64'h0300, 8'h03, 0, 0);
        rd('h000, d2, r0, e0);
        repeat (20) step();
        rd('h000, d3, r0, e0);
        chk("psc_freeze", d3, d2);
`else
        d0 = '0; d1 = '0; d2 = '0; d3 = '0; r0 = '0; e0 = 0;
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/axi4lite_timer.md
Name: axi4lite_timer

Overview:
- Memory-mapped machine timer (mtime/mtimecmp) on a 64-bit AXI4-Lite slave port, hung off one slave slot of the system crossbar.
- Drives a level timer interrupt into one bit of the core's int_platform vector, i.e. the stage directly upstream of the core's interrupt input.
- Single clock domain. Independent read and write channels, at most one transaction outstanding per channel.

Parameters:
- ADDR_WIDTH, `ALEN: AXI address width.
- ADDR_MASK, {3'b000, {(`ALEN-3){1'b1}}}: ANDed with the incoming address before offset decode.
- CMP_RESET, 64'hFFFF_FFFF_FFFF_FFFF: reset value of MTIMECMP.

Ports:
- aclk  in  1  Sole clock.
- aresetn  in  1  Reset, asynchronous assert, active-low.
- awaddr  in  ADDR_WIDTH  Write address.
- awprot  in  3  Ignored.
- awvalid  in  1  /  awready  out  1.
- wdata  in  64  /  wstrb  in  8  /  wvalid  in  1  /  wready  out  1.
- bresp  out  2  /  bvalid  out  1  /  bready  in  1.
- araddr  in  ADDR_WIDTH  /  arprot  in  3 (ignored)  /  arvalid  in  1  /  arready  out  1.
- rdata  out  64  /  rresp  out  2  /  rvalid  out  1  /  rready  in  1.
- irq  out  1  Timer interrupt, level, registered.

Behaviour:
- Reset (async, aresetn=0) values:
  - MTIME=0, MTIMECMP=CMP_RESET, CTRL.EN=1.
  - irq=0, bvalid=0, rvalid=0, rdata=0, bresp=0, rresp=0.
  - awready=0, wready=0, arready=0.
  - Ready signals go to 1 on the first clock after reset deasserts.
- Register map. Offset = (addr & ADDR_MASK), bits [4:3] select; bits [2:0] must be 0:
  - 0x00 MTIME, RW.
  - 0x08 MTIMECMP, RW.
  - 0x10 CTRL, RW. [0]=EN, [15:8]=PRESCALE (see optional feature), other bits read 0.
  - 0x18 or nonzero bits [2:0]: unmapped. Writes are dropped with bresp=SLVERR (2'b10). Reads return rdata=0 with rresp=SLVERR.
- Counter:
  - When EN=1 and a tick occurs, MTIME <= MTIME+1 modulo 2^64; 0xFFFF_FFFF_FFFF_FFFF wraps to 0.
  - Without prescaler, a tick occurs every cycle.
  - A software write to MTIME in the same cycle as an increment wins; the increment is lost.
- Write channel FSM, states W_IDLE, W_RESP:
  - W_IDLE: AW and W are accepted independently. awready drops after the AW beat is latched, wready drops after the W beat is latched.
  - Once both are latched: apply the write byte-wise per wstrb (strb bit i covers bits [8i+7:8i]), set bvalid=1, go to W_RESP. Both beats arriving in the same cycle completes in one cycle.
  - W_RESP: hold bvalid, bresp, awready=0, wready=0 until bready. Then go back to W_IDLE with awready=wready=1 on the next cycle.
- Read channel FSM, states R_IDLE, R_RESP:
  - R_IDLE with arready=1: on arvalid, register rdata/rresp on the next edge, set rvalid=1, drop arready.
  - R_RESP: rdata is stable until rready, then back to R_IDLE.
  - Read latency is 1 cycle from the AR handshake.
  - A read and a write to the same register in the same cycle: the read returns the pre-write value.
- Interrupt:
  - irq <= EN-independent compare (MTIME >= MTIMECMP), unsigned 64-bit, one cycle after the register values.
  - Writing MTIMECMP above MTIME clears irq on the cycle after the write commits.
  - Partial-strobe writes to MTIMECMP are visible to the compare immediately; software sequencing is its own concern.
- Reset mid-transaction: all state is abandoned, no response is issued, and the FSMs restart in idle.

Optional Feature:
- Macro: TIMER_PRESCALER_EN.
- Defined:
  - CTRL[15:8] PRESCALE is RW, reset 0.
  - An 8-bit divider counts 0..PRESCALE, and a tick fires when it equals PRESCALE; PRESCALE=0 means a tick every cycle.
  - Writing PRESCALE resets the divider to 0.
  - EN=0 freezes the divider.
- Undefined: PRESCALE reads 0, writes are ignored, and a tick occurs every cycle while EN=1.

Decomposition:
- Package timer_pkg:
  - Offset constants TIMER_MTIME_OFF=5'h00, TIMER_MTIMECMP_OFF=5'h08, TIMER_CTRL_OFF=5'h10.
  - CTRL bit positions.
  - AXI response constants RESP_OKAY=2'b00, RESP_SLVERR=2'b10.
  - Enum types for the write FSM (W_IDLE, W_RESP) and read FSM (R_IDLE, R_RESP).
- One sub-module, timer_prescaler:
  - Inputs: aclk, aresetn, en, prescale[7:0], prescale_wr.
  - Output: tick.
  - Instantiated only under TIMER_PRESCALER_EN; otherwise tick=en.

Test Plan:
- Reset then idle 10 cycles, no bus traffic -> read MTIME returns a value in 9..11 with rresp=0, irq=0, and read MTIMECMP returns 64'hFFFF_FFFF_FFFF_FFFF.
- Write MTIMECMP=64'd100 then MTIME=64'd95, wstrb=8'hFF -> irq rises 6 or 7 cycles after the MTIME write commits. Writing MTIMECMP=64'd1000 then drops irq exactly 1 cycle after commit.
- AW presented 3 cycles before W, with bready held low 4 cycles -> awready low after the AW beat, single bvalid held stable until bready, no second write applied.
- Write MTIME=64'hFFFF_FFFF_FFFF_FFFE with EN=1 -> MTIME reads back wrapped to a small value (0..3), and irq is set with MTIMECMP=CMP_RESET until the wrap, then cleared.
- Read offset 0x18 and write offset 0x0C -> rresp=2'b10 with rdata=0, bresp=2'b10, and no register changes.
- With TIMER_PRESCALER_EN, CTRL=0x0301 -> MTIME advances by 1 every 4 cycles (100 cycles give +25±1). Writing EN=0 freezes MTIME.
